// File: rtl/riscv_mem_arbiter_if.sv
// Requester-side and memory-side bus of the instruction/data memory arbiter.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface riscv_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wmask;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rstrb;
    logic [DATA_W-1:0] mem_rdata;

    logic              arb_busy;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb, arb_busy
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wdata, d_wmask, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, arb_busy
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for a single-ported sync-read memory: IDLE -> ACCESS -> RESP per request.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is data-over-fetch priority.
module riscv_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    riscv_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_grant;
    logic [ADDR_W-3:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_wmask;
    logic              r_mem_rstrb;
    logic              w_win_data;
    logic              w_grant_en;
    logic              w_unused_addr_bits;

    assign w_unused_addr_bits = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // On a tie, the port that did not win last time takes the grant.
    assign w_win_data = bus.d_req && (!bus.if_req || !r_last_grant);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= 1'b0;
        end else if (w_grant_en) begin
            r_last_grant <= w_win_data;
        end
    end
`else
    assign w_win_data = bus.d_req;
`endif

    assign w_grant_en = (r_state == StIdle) && (bus.if_req || bus.d_req);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_grant_en) w_state_next = StAccess;
            StAccess: w_state_next = StResp;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_grant     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= 4'b0;
            r_mem_rstrb <= 1'b0;
        end else if (w_grant_en) begin
            r_grant <= w_win_data;
            if (w_win_data) begin
                r_mem_addr  <= bus.d_addr[ADDR_W-1:2];
                r_mem_wdata <= bus.d_wdata;
                r_mem_wmask <= bus.d_wmask;
                r_mem_rstrb <= (bus.d_wmask == 4'b0);
            end else begin
                r_mem_addr  <= bus.if_addr[ADDR_W-1:2];
                r_mem_wdata <= '0;
                r_mem_wmask <= 4'b0;
                r_mem_rstrb <= 1'b1;
            end
        end else if (r_state == StAccess) begin
            // Strobes last exactly one cycle; address and data stay until the next grant.
            r_mem_wmask <= 4'b0;
            r_mem_rstrb <= 1'b0;
        end
    end

    always_comb begin
        bus.if_ack    = (r_state == StResp) && !r_grant;
        bus.d_ack     = (r_state == StResp) && r_grant;
        bus.if_rdata  = bus.if_ack ? bus.mem_rdata : '0;
        bus.d_rdata   = bus.d_ack ? bus.mem_rdata : '0;
        bus.arb_busy  = (r_state != StIdle);
        bus.mem_addr  = r_mem_addr;
        bus.mem_wdata = r_mem_wdata;
        bus.mem_wmask = r_mem_wmask;
        bus.mem_rstrb = r_mem_rstrb;
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a 16-word synchronous-read memory model.
module tb_riscv_mem_arbiter;
    logic        clk;
    logic        resetn;
    logic        mem_load;
    logic [31:0] mem [16];
    logic [31:0] mem_rdata_q;
    int          checks;
    int          errors;

    riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: MEM[i] = 0xA5A5_0000 + i after load; byte-lane writes, registered read.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
            mem_rdata_q <= 32'h0;
        end else begin
            if (bus.mem_rstrb) mem_rdata_q <= mem[bus.mem_addr[3:0]];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wmask[b]) mem[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_req   = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        bus.d_wmask = 4'b0;
    endtask

    initial begin
        logic exp_data;
        checks   = 0;
        errors   = 0;
        mem_load = 1'b1;
        resetn   = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        mem_load = 1'b0;

        check("rst_busy", bus.arb_busy, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_wmask", bus.mem_wmask, 0);
        check("rst_rstrb", bus.mem_rstrb, 0);
        check("rst_if_ack", bus.if_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        resetn = 1'b1;
        cyc();

        // Fetch from 0x8
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h8;
        cyc();
        check("t1_addr", bus.mem_addr, 2);
        check("t1_rstrb", bus.mem_rstrb, 1);
        check("t1_wmask", bus.mem_wmask, 0);
        check("t1_busy", bus.arb_busy, 1);
        check("t1_ack_early", bus.if_ack, 0);
        cyc();
        check("t1_if_ack", bus.if_ack, 1);
        check("t1_if_rdata", bus.if_rdata, 32'hA5A5_0002);
        check("t1_d_ack", bus.d_ack, 0);
        check("t1_rstrb_off", bus.mem_rstrb, 0);
        bus.if_req = 1'b0;
        cyc();
        check("t1_ack_pulse", bus.if_ack, 0);
        check("t1_busy_off", bus.arb_busy, 0);
        check("t1_addr_hold", bus.mem_addr, 2);

        // Half-word store to 0x14
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h14;
        bus.d_wmask = 4'b0011;
        bus.d_wdata = 32'hDEAD_BEEF;
        cyc();
        check("t2_wmask", bus.mem_wmask, 4'b0011);
        check("t2_rstrb", bus.mem_rstrb, 0);
        check("t2_addr", bus.mem_addr, 5);
        check("t2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        cyc();
        check("t2_d_ack", bus.d_ack, 1);
        check("t2_if_ack", bus.if_ack, 0);
        check("t2_wmask_off", bus.mem_wmask, 0);
        check("t2_rstrb_resp", bus.mem_rstrb, 0);
        bus.d_req = 1'b0;
        cyc();
        check("t2_ack_pulse", bus.d_ack, 0);

        // Misaligned load reads back MEM[5]
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h17;
        bus.d_wmask = 4'b0;
        cyc();
        check("t2l_addr", bus.mem_addr, 5);
        check("t2l_rstrb", bus.mem_rstrb, 1);
        cyc();
        check("t2l_d_ack", bus.d_ack, 1);
        check("t2l_d_rdata", bus.d_rdata, 32'hA5A5_BEEF);
        bus.d_req = 1'b0;
        cyc();

        // Reset so tie-breaking starts from the same point in both configurations
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();

        // Simultaneous requests: data first, fetch three cycles later
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0;
        bus.d_wmask = 4'b0;
        cyc();
        check("t3_addr_d", bus.mem_addr, 0);
        cyc();
        check("t3_d_ack", bus.d_ack, 1);
        check("t3_if_ack_lose", bus.if_ack, 0);
        check("t3_d_rdata", bus.d_rdata, 32'hA5A5_0000);
        bus.d_req = 1'b0;
        cyc();
        check("t3_idle_busy", bus.arb_busy, 0);
        check("t3_idle_ack", bus.if_ack, 0);
        cyc();
        check("t3_addr_if", bus.mem_addr, 1);
        check("t3_if_ack_early", bus.if_ack, 0);
        cyc();
        check("t3_if_ack", bus.if_ack, 1);
        check("t3_if_rdata", bus.if_rdata, 32'hA5A5_0001);
        check("t3_d_ack_off", bus.d_ack, 0);
        bus.if_req = 1'b0;
        cyc();

        // Both held for four transactions
        bus.if_req  = 1'b1;
        bus.if_addr = 32'hC;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h8;
        bus.d_wmask = 4'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_data = (k % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            cyc();
            check("t4_busy", bus.arb_busy, 1);
            cyc();
            check("t4_d_ack", bus.d_ack, exp_data);
            check("t4_if_ack", bus.if_ack, !exp_data);
            if (exp_data) check("t4_d_rdata", bus.d_rdata, 32'hA5A5_0002);
            else check("t4_if_rdata", bus.if_rdata, 32'hA5A5_0003);
            cyc();
            check("t4_gap", bus.arb_busy, 0);
        end
        idle_inputs();
        cyc();

        // Reset during ACCESS of a fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4;
        cyc();
        check("t5_access", bus.mem_rstrb, 1);
        resetn = 1'b0;
        cyc();
        check("t5_if_ack", bus.if_ack, 0);
        check("t5_busy", bus.arb_busy, 0);
        check("t5_rstrb", bus.mem_rstrb, 0);
        check("t5_addr", bus.mem_addr, 0);
        check("t5_if_rdata", bus.if_rdata, 0);
        resetn = 1'b1;
        cyc();
        check("t5_re_addr", bus.mem_addr, 1);
        check("t5_re_ack_early", bus.if_ack, 0);
        cyc();
        check("t5_re_ack", bus.if_ack, 1);
        check("t5_re_rdata", bus.if_rdata, 32'hA5A5_0001);
        bus.if_req = 1'b0;
        cyc();

        // Address change after the grant edge is ignored
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        check("t6_busy0", bus.arb_busy, 0);
        cyc();
        check("t6_busy1", bus.arb_busy, 1);
        bus.if_addr = 32'hC;
        cyc();
        check("t6_busy2", bus.arb_busy, 1);
        check("t6_if_ack", bus.if_ack, 1);
        check("t6_if_rdata", bus.if_rdata, 32'hA5A5_0000);
        check("t6_addr_hold", bus.mem_addr, 0);
        bus.if_req = 1'b0;
        cyc();
        check("t6_busy3", bus.arb_busy, 0);
        cyc();
        check("t6_busy4", bus.arb_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
